// File: rtl/iso_tree_scorer_pkg.sv
// iso_tree_pkg: shared types and sizing helpers for the isolation-tree scorer.
//   state_t  : walk FSM states (S_IDLE, S_WALK, S_DONE)
//   node_cnt : number of tree nodes for a given depth (2**depth-1)
//   ch_w     : channel index width, minimum 1
//   pl_w     : path-length width, wide enough for 0..depth
package iso_tree_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_DONE
    } state_t;

    function automatic int node_cnt(input int depth);
        return (1 << depth) - 1;
    endfunction

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/iso_tree_scorer_if.sv
// iso_tree_scorer_if: sample-in / result-out streams of the scorer.
//   in_valid/in_ready/in_data/in_ch           : sample stream into the block
//   out_valid/out_ready/out_ch/out_path_len/out_anomaly : result stream out
//   master : the side that produces samples and consumes results
//   slave  : the scorer itself
interface iso_tree_scorer_if #(
    parameter int DATA_W = 8,
    parameter int CH_W   = 2,
    parameter int PL_W   = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CH_W-1:0]   in_ch;
    logic              out_valid;
    logic              out_ready;
    logic [CH_W-1:0]   out_ch;
    logic [PL_W-1:0]   out_path_len;
    logic              out_anomaly;

    modport master (
        output in_valid, in_data, in_ch, out_ready,
        input  in_ready, out_valid, out_ch, out_path_len, out_anomaly
    );

    modport slave (
        input  in_valid, in_data, in_ch, out_ready,
        output in_ready, out_valid, out_ch, out_path_len, out_anomaly
    );
endinterface

// File: rtl/iso_tree_scorer_node_mem.sv
// iso_node_mem: register file holding the isolation tree, one entry per node
// in heap order (root = 0). Each entry is a threshold plus a leaf bit.
//   clk, reset : clock, synchronous active-high reset (clears every node)
//   we, waddr, wthr, wleaf : synchronous write; waddr beyond the last node is ignored
//   raddr -> rthr, rleaf   : asynchronous read of the node being walked
module iso_node_mem
    import iso_tree_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [DEPTH-1:0]  waddr,
    input  logic [DATA_W-1:0] wthr,
    input  logic              wleaf,
    input  logic [DEPTH-1:0]  raddr,
    output logic [DATA_W-1:0] rthr,
    output logic              rleaf
);
    localparam int NODES = node_cnt(DEPTH);

    logic [NODES-1:0][DATA_W-1:0] thr_q;
    logic [NODES-1:0]             leaf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            thr_q  <= '0;
            leaf_q <= '0;
        end else if (we && (int'(waddr) < NODES)) begin
            thr_q[waddr]  <= wthr;
            leaf_q[waddr] <= wleaf;
        end
    end

    // The walk never forms an index past the last node; the guard keeps the
    // unused top code of raddr well defined.
    assign rthr  = (int'(raddr) < NODES) ? thr_q[raddr]  : '0;
    assign rleaf = (int'(raddr) < NODES) ? leaf_q[raddr] : 1'b0;
endmodule

// File: rtl/iso_tree_scorer.sv
// iso_tree_scorer: scores each sensor sample by walking a runtime-loaded
// isolation tree one level per clock. A short path (early isolation) marks
// the sample as an anomaly; anomalies set per-channel sticky flags.
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : sample stream in, result stream out (ch, path_len, anomaly)
//   cfg_we/addr/thr/leaf : node write port, honoured only while idle
//   clear_flags       : clears all sticky flags (a same-cycle set wins)
//   anomaly_flags     : per-channel sticky anomaly flags
//   anomaly_detected  : registered OR of anomaly_flags
// Optional build macro ISO_CONSEC_FILTER_EN: a flag is only set after
// CONSEC_N consecutive anomalous results on that channel.
module iso_tree_scorer
    import iso_tree_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 4,
    parameter int DEPTH     = 4,
    parameter int SCORE_THR = 2,
    parameter int CONSEC_N  = 3
) (
    input  logic              clk,
    input  logic              reset,
    iso_tree_scorer_if.slave  bus,
    input  logic              cfg_we,
    input  logic [DEPTH-1:0]  cfg_addr,
    input  logic [DATA_W-1:0] cfg_thr,
    input  logic              cfg_leaf,
    input  logic              clear_flags,
    output logic [NUM_CH-1:0] anomaly_flags,
    output logic              anomaly_detected
);
    localparam int CH_W = ch_w(NUM_CH);
    localparam int PL_W = pl_w(DEPTH);

    state_t            state;
    logic [DATA_W-1:0] data_q;
    logic [CH_W-1:0]   ch_q;
    logic [DEPTH-1:0]  idx;
    logic [PL_W-1:0]   lvl;
    logic              out_valid_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [PL_W-1:0]   out_pl_q;
    logic              out_anom_q;

    logic [DATA_W-1:0] node_thr;
    logic              node_leaf;
    logic              term;
    logic [PL_W-1:0]   pl_next;
    logic              anom_next;
    logic              done_evt;

    iso_node_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (cfg_we && (state == S_IDLE)),
        .waddr (cfg_addr),
        .wthr  (cfg_thr),
        .wleaf (cfg_leaf),
        .raddr (idx),
        .rthr  (node_thr),
        .rleaf (node_leaf)
    );

    // Config writes take priority over samples while idle.
    assign bus.in_ready     = (state == S_IDLE) && !cfg_we;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_ch       = out_ch_q;
    assign bus.out_path_len = out_pl_q;
    assign bus.out_anomaly  = out_anom_q;

    assign term      = node_leaf || (lvl == PL_W'(DEPTH - 1));
    assign pl_next   = lvl + PL_W'(1);
    assign anom_next = int'(pl_next) < SCORE_THR;
    assign done_evt  = (state == S_WALK) && term;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            data_q      <= '0;
            ch_q        <= '0;
            idx         <= '0;
            lvl         <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_pl_q    <= '0;
            out_anom_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        data_q <= bus.in_data;
                        ch_q   <= bus.in_ch;
                        idx    <= '0;
                        lvl    <= '0;
                        state  <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (term) begin
                        out_valid_q <= 1'b1;
                        out_ch_q    <= ch_q;
                        out_pl_q    <= pl_next;
                        out_anom_q  <= anom_next;
                        state       <= S_DONE;
                    end else begin
                        // Heap order: children of n are 2n+1 (less) and 2n+2.
                        idx <= (idx << 1) + ((data_q < node_thr) ? DEPTH'(1) : DEPTH'(2));
                        lvl <= pl_next;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Per-channel flag set requests for the result being produced this cycle.
    // Out-of-range channels never match any c, so they touch nothing.
    logic [NUM_CH-1:0] set_vec;

`ifdef ISO_CONSEC_FILTER_EN
    localparam int CNT_W = $clog2(CONSEC_N + 1);
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_nxt;

    always_comb begin
        set_vec = '0;
        cnt_nxt = cnt_q;
        for (int c = 0; c < NUM_CH; c++) begin
            // Clear first, so a same-cycle result counts from zero.
            if (clear_flags) cnt_nxt[c] = '0;
            if (done_evt && (ch_q == CH_W'(c))) begin
                if (anom_next) begin
                    if (cnt_nxt[c] != CNT_W'(CONSEC_N)) cnt_nxt[c] = cnt_nxt[c] + CNT_W'(1);
                    set_vec[c] = (cnt_nxt[c] == CNT_W'(CONSEC_N));
                end else begin
                    cnt_nxt[c] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_nxt;
    end
`else
    always_comb begin
        set_vec = '0;
        for (int c = 0; c < NUM_CH; c++)
            set_vec[c] = done_evt && anom_next && (ch_q == CH_W'(c));
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            anomaly_flags    <= '0;
            anomaly_detected <= 1'b0;
        end else begin
            anomaly_flags    <= set_vec | (clear_flags ? '0 : anomaly_flags);
            anomaly_detected <= |anomaly_flags;
        end
    end
endmodule
